// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - 3-wire SPI serial engine for AD9434 register access
module adc_spi_master #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int CLK_DIV         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_spi_wr_cmd,
    input  logic                       i_spi_rd_cmd,
    input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
    output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
    output logic                       o_spi_rd_valid,
    output logic                       o_spi_busy,
    output logic                       o_spi_csb,
    output logic                       o_spi_sclk,
    output logic                       o_spi_sdio_o,
    output logic                       o_spi_sdio_oe,
    input  logic                       i_spi_sdio_i
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(MOSI_DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(MOSI_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] RX_TOP    = BIT_W'(MISO_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] TURN_FROM = BIT_W'(MISO_DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                     state, state_n;
    logic [DIV_W-1:0]           div_cnt, div_cnt_n;
    logic [BIT_W-1:0]           bit_cnt, bit_cnt_n;
    logic [MOSI_DATA_WIDTH-1:0] frame, frame_n;
    logic [MISO_DATA_WIDTH-1:0] rx_shift, rx_shift_n;
    logic [MISO_DATA_WIDTH-1:0] rd_data_n;
    logic                       is_read, is_read_n;
    logic                       csb_n, sclk_n, oe_n, busy_n, rd_valid_n;
    logic                       div_done;

    assign div_done     = (div_cnt == DIV_LAST);
    // frame MSB is always the bit currently on the wire
    assign o_spi_sdio_o = frame[MOSI_DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            frame          <= '0;
            rx_shift       <= '0;
            is_read        <= 1'b0;
            o_spi_csb      <= 1'b1;
            o_spi_sclk     <= 1'b0;
            o_spi_sdio_oe  <= 1'b0;
            o_spi_busy     <= 1'b0;
            o_spi_rd_data  <= '0;
            o_spi_rd_valid <= 1'b0;
        end else begin
            state          <= state_n;
            div_cnt        <= div_cnt_n;
            bit_cnt        <= bit_cnt_n;
            frame          <= frame_n;
            rx_shift       <= rx_shift_n;
            is_read        <= is_read_n;
            o_spi_csb      <= csb_n;
            o_spi_sclk     <= sclk_n;
            o_spi_sdio_oe  <= oe_n;
            o_spi_busy     <= busy_n;
            o_spi_rd_data  <= rd_data_n;
            o_spi_rd_valid <= rd_valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_cnt_n  = div_done ? '0 : div_cnt + 1'b1;
        bit_cnt_n  = bit_cnt;
        frame_n    = frame;
        rx_shift_n = rx_shift;
        is_read_n  = is_read;
        csb_n      = o_spi_csb;
        sclk_n     = o_spi_sclk;
        oe_n       = o_spi_sdio_oe;
        busy_n     = o_spi_busy;
        rd_data_n  = o_spi_rd_data;
        rd_valid_n = 1'b0;
        case (state)
            IDLE: begin
                div_cnt_n = '0;
                if (i_spi_wr_cmd || i_spi_rd_cmd) begin
                    // simultaneous wr+rd resolves to a read
                    is_read_n                   = i_spi_rd_cmd;
                    frame_n                     = i_spi_wr_data;
                    frame_n[MOSI_DATA_WIDTH-1]  = i_spi_rd_cmd;
                    bit_cnt_n                   = BIT_TOP;
                    csb_n                       = 1'b0;
                    busy_n                      = 1'b1;
                    oe_n                        = 1'b1;
                    state_n                     = SETUP;
                end
            end
            SETUP: begin
                if (div_done) state_n = SHIFT;
            end
            SHIFT: begin
                if (div_done && !o_spi_sclk) begin
                    sclk_n = 1'b1;
                    if (is_read && bit_cnt <= RX_TOP)
                        rx_shift_n = {rx_shift[MISO_DATA_WIDTH-2:0], i_spi_sdio_i};
                end else if (div_done) begin
                    sclk_n = 1'b0;
                    if (bit_cnt == '0) begin
                        state_n = HOLD;
                        if (is_read) begin
                            rd_data_n  = rx_shift;
                            rd_valid_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt - 1'b1;
                        frame_n   = {frame[MOSI_DATA_WIDTH-2:0], 1'b0};
                        // release SDIO once the last address bit has been sampled
                        if (is_read && bit_cnt == TURN_FROM) oe_n = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (div_done) begin
                    csb_n   = 1'b1;
                    oe_n    = 1'b0;
                    frame_n = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (div_done) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_spi_master.sv
// tb/tb_adc_spi_master.sv - scoreboard bench for adc_spi_master
module tb_adc_spi_master;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_cmd = 1'b0, rd_cmd = 1'b0;
    logic [23:0] wr_data = '0;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, csb, sclk, sdio_o, sdio_oe, sdio_i;

    adc_spi_master #(.MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .i_spi_wr_cmd(wr_cmd), .i_spi_rd_cmd(rd_cmd),
        .i_spi_wr_data(wr_data), .o_spi_rd_data(rd_data), .o_spi_rd_valid(rd_valid),
        .o_spi_busy(busy), .o_spi_csb(csb), .o_spi_sclk(sclk), .o_spi_sdio_o(sdio_o),
        .o_spi_sdio_oe(sdio_oe), .i_spi_sdio_i(sdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {logic [23:0] frame; logic rd;} exp_t;
    typedef struct {
        logic wr; logic rd; logic [23:0] data; logic [7:0] slave;
        logic [23:0] exp_frame; logic exp_read; logic [7:0] exp_rd;
    } vec_t;

    exp_t       frame_q[$];
    logic [7:0] rd_q[$];
    int         n_checks = 0, n_fail = 0;
    int         rise_cnt = 0, frames_done = 0, rdv_cnt = 0, gap_seen = 0;
    logic [7:0] slave_byte = '0;
    logic [7:0] last_rd = '0;

    // slave presents read bits during the low phase before rising edges 16..23
    always_comb begin
        sdio_i = 1'b0;
        if (rise_cnt >= 16 && rise_cnt < 24) sdio_i = slave_byte[23 - rise_cnt];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [23:0] cap, oe_cap, mask;
        int low_cnt, high_cnt;
        logic csb_prev, sclk_prev, sdio_prev;
        exp_t e;
        cap = '0; oe_cap = '0; low_cnt = 0; high_cnt = 0;
        csb_prev = 1'b1; sclk_prev = 1'b0; sdio_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rise_cnt = 0; cap = '0; oe_cap = '0; low_cnt = 0; high_cnt = 0;
                csb_prev = 1'b1; sclk_prev = 1'b0; sdio_prev = 1'b0;
            end else begin
                if (rd_valid) begin
                    rdv_cnt++;
                    check("rd_valid_in_hold", {30'd0, csb, sclk}, 0);
                    if (rd_q.size() == 0) check("rd_valid_unexpected", 1, 0);
                    else check("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
                end
                if (sclk && sclk_prev) check("sdio_stable_high", {31'd0, sdio_o}, {31'd0, sdio_prev});
                if (sclk && !sclk_prev) begin
                    cap = {cap[22:0], sdio_o};
                    oe_cap = {oe_cap[22:0], sdio_oe};
                    rise_cnt++;
                end
                if (!csb && csb_prev) begin
                    gap_seen = high_cnt;
                    high_cnt = 0;
                end
                if (!csb) low_cnt++;
                else high_cnt++;
                if (csb && !csb_prev) begin
                    if (frame_q.size() == 0) check("frame_unexpected", 1, 0);
                    else begin
                        e = frame_q.pop_front();
                        mask = e.rd ? 24'hFFFF00 : 24'hFFFFFF;
                        check("sclk_rises", rise_cnt, 24);
                        check("frame_bits", {8'd0, cap & mask}, {8'd0, e.frame & mask});
                        check("sdio_oe_pattern", {8'd0, oe_cap}, {8'd0, mask});
                        check("csb_low_cycles", low_cnt, 50 * CD);
                    end
                    frames_done++;
                    rise_cnt = 0; cap = '0; oe_cap = '0; low_cnt = 0;
                end
                csb_prev = csb; sclk_prev = sclk; sdio_prev = sdio_o;
            end
        end
    endtask

    task automatic drive_cmd(input logic w, input logic r, input logic [23:0] d);
        wr_cmd = w; rd_cmd = r; wr_data = d;
        @(posedge clk);
        #1;
        wr_cmd = 1'b0; rd_cmd = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[6];
    int   n, f0, r0;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 24'h000818, 8'h00, 24'h000818, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 24'h000100, 8'h6A, 24'h800100, 1'b1, 8'h6A};
        vecs[2] = '{1'b1, 1'b1, 24'h000818, 8'hA5, 24'h800818, 1'b1, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 24'h8FFFFF, 8'h00, 24'h0FFFFF, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 24'h7FFF00, 8'h81, 24'hFFFF00, 1'b1, 8'h81};
        vecs[5] = '{1'b1, 1'b0, 24'h555555, 8'h00, 24'h555555, 1'b0, 8'h00};

        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_csb", {31'd0, csb}, 1);
        check("reset_sclk", {31'd0, sclk}, 0);
        check("reset_sdio", {30'd0, sdio_o, sdio_oe}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rd", {23'd0, rd_valid, rd_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            slave_byte = vecs[i].slave;
            frame_q.push_back('{vecs[i].exp_frame, vecs[i].exp_read});
            if (vecs[i].exp_read) begin
                rd_q.push_back(vecs[i].exp_rd);
                last_rd = vecs[i].exp_rd;
            end
            f0 = frames_done; r0 = rdv_cnt;
            drive_cmd(vecs[i].wr, vecs[i].rd, vecs[i].data);
            wait_idle(n);
            check("busy_cycles", n, 51 * CD);
            repeat (3) @(negedge clk);
            check("frames_per_cmd", frames_done - f0, 1);
            check("rd_valid_pulses", rdv_cnt - r0, {31'd0, vecs[i].exp_read});
            check("rd_data_held", {24'd0, rd_data}, {24'd0, last_rd});
        end

        // command while busy is dropped
        f0 = frames_done; r0 = rdv_cnt;
        frame_q.push_back('{24'h000818, 1'b0});
        drive_cmd(1'b1, 1'b0, 24'h000818);
        repeat (10) @(negedge clk);
        drive_cmd(1'b1, 1'b1, 24'hFFFFFF);
        wait_idle(n);
        repeat (20) @(negedge clk);
        check("busy_drop_frames", frames_done - f0, 1);
        check("busy_drop_no_rd", rdv_cnt - r0, 0);
        check("busy_drop_queue", frame_q.size(), 0);

        // reset in the middle of a read
        slave_byte = 8'h3C;
        f0 = frames_done; r0 = rdv_cnt;
        frame_q.push_back('{24'h800100, 1'b1});
        rd_q.push_back(8'h3C);
        drive_cmd(1'b0, 1'b1, 24'h000100);
        n = 0;
        while (rise_cnt < 12 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("reach_bit12", rise_cnt >= 12, 1);
        rst_n = 1'b0;
        frame_q.delete(); rd_q.delete();
        @(negedge clk);
        check("midrst_csb_sclk", {30'd0, csb, sclk}, 2);
        check("midrst_oe_busy", {30'd0, sdio_oe, busy}, 0);
        check("midrst_rd", {23'd0, rd_valid, rd_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("midrst_no_rd_valid", rdv_cnt - r0, 0);
        check("midrst_no_frame", frames_done - f0, 0);
        check("midrst_rd_data", {24'd0, rd_data}, 0);
        check("midrst_idle", {30'd0, csb, busy}, 2);

        // back-to-back commands
        f0 = frames_done;
        frame_q.push_back('{24'h123456, 1'b0});
        frame_q.push_back('{24'h0ABCDE, 1'b0});
        drive_cmd(1'b1, 1'b0, 24'h123456);
        wait_idle(n);
        check("b2b_busy_first", n, 51 * CD);
        drive_cmd(1'b1, 1'b0, 24'h0ABCDE);
        wait_idle(n);
        check("b2b_busy_second", n, 51 * CD);
        repeat (3) @(negedge clk);
        check("b2b_frames", frames_done - f0, 2);
        check("b2b_gap", gap_seen >= CD + 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
